// File: rtl/risc8_writeback_if.sv
// risc8_writeback_if
// Groups the write-back block's source, hazard-query and register-file
// signals.
//   master : execute/memory side (drives the result sources and the hazard
//            query, receives stall and the register-file write port)
//   slave  : the write-back arbiter
//
// Handshake: every source is valid-only. alu_write, ptr_write, ld_issue and
// mem_valid each describe one event in the cycle they are high, and no ready
// comes back. Back-pressure reaches the producers through `stall`, which the
// issue logic must honour before it starts another instruction.
interface risc8_writeback_if;
    logic        alu_write;
    logic        alu_word;
    logic [5:0]  alu_d;
    logic [15:0] alu_Rd;
    logic        ptr_write;
    logic [5:0]  ptr_d;
    logic [15:0] ptr_Rd;
    logic        ld_issue;
    logic [5:0]  ld_d;
    logic        mem_valid;
    logic [7:0]  mem_rdata;
    logic [5:0]  hz_a;
    logic [5:0]  hz_b;
    logic        stall;
    logic        write;
    logic        write_word;
    logic [5:0]  d;
    logic [15:0] Rd;
    logic        ld_pending;
    logic        err;

    modport master (
        output alu_write, alu_word, alu_d, alu_Rd,
        output ptr_write, ptr_d, ptr_Rd,
        output ld_issue, ld_d, mem_valid, mem_rdata,
        output hz_a, hz_b,
        input  stall, write, write_word, d, Rd, ld_pending, err
    );

    modport slave (
        input  alu_write, alu_word, alu_d, alu_Rd,
        input  ptr_write, ptr_d, ptr_Rd,
        input  ld_issue, ld_d, mem_valid, mem_rdata,
        input  hz_a, hz_b,
        output stall, write, write_word, d, Rd, ld_pending, err
    );
endinterface

// File: rtl/risc8_writeback.sv
// risc8_writeback
// Write-back arbiter for the risc8 register file's single write port. It
// merges load returns, ALU results and pointer updates into one write per
// cycle, using fixed priority load > ALU > pointer. Each losing ALU or pointer
// result waits in a one-entry hold register. `stall` keeps the issue logic
// from reading a register whose write is still held or pending here.
// Ports:
//   clk, reset : core clock, synchronous active-high reset
//   wb (slave) : sources (alu_*, ptr_*, ld_*, mem_*), hazard query (hz_a,
//                hz_b), combinational stall, and the registered regfile port
//                (write, write_word, d, Rd) plus ld_pending and a sticky err.
module risc8_writeback (
    input  logic              clk,
    input  logic              reset,
    risc8_writeback_if.slave  wb
);

    // Returns 1 when byte address rd_byte falls inside the destination.
    // A word destination covers a whole register pair.
    function automatic logic covers(input logic [5:0] rd_byte,
                                    input logic [5:0] dest,
                                    input logic       word);
        if (word)
            covers = (rd_byte[5:1] == dest[5:1]);
        else
            covers = (rd_byte == dest);
    endfunction

    // The A port reads a pair {a, a|1}, and the B port reads a single byte.
    function automatic logic reads_hit(input logic [5:0] a,
                                       input logic [5:0] b,
                                       input logic [5:0] dest,
                                       input logic       word);
        reads_hit = covers(a, dest, word) | covers({a[5:1], 1'b1}, dest, word)
                  | covers(b, dest, word);
    endfunction

    // State
    logic        ld_pending_q;
    logic [5:0]  ld_dest_q;
    logic        alu_hold_valid;
    logic        alu_hold_word;
    logic [5:0]  alu_hold_d;
    logic [15:0] alu_hold_rd;
    logic        ptr_hold_valid;
    logic [5:0]  ptr_hold_d;
    logic [15:0] ptr_hold_rd;
    logic        write_q;
    logic        write_word_q;
    logic [5:0]  d_q;
    logic [15:0] rd_q;
    logic        err_q;

    // Incoming candidates, already put into register-file format
    logic        ld_ret;
    logic [5:0]  alu_in_d;
    logic [15:0] alu_in_rd;
    logic [5:0]  ptr_in_d;

    // Effective ALU / pointer candidate (the held entry wins over incoming)
    logic        alu_cand_valid;
    logic        alu_cand_word;
    logic [5:0]  alu_cand_d;
    logic [15:0] alu_cand_rd;
    logic        ptr_cand_valid;
    logic [5:0]  ptr_cand_d;
    logic [15:0] ptr_cand_rd;

    // Winner of this cycle
    logic        win_valid;
    logic        win_word;
    logic [5:0]  win_d;
    logic [15:0] win_rd;

    logic        hazard;

    always_comb begin
        ld_ret    = wb.mem_valid & ld_pending_q;
        alu_in_d  = wb.alu_word ? {wb.alu_d[5:1], 1'b0} : wb.alu_d;
        alu_in_rd = wb.alu_word ? wb.alu_Rd : {8'h00, wb.alu_Rd[7:0]};
        ptr_in_d  = {wb.ptr_d[5:1], 1'b0};

        alu_cand_valid = alu_hold_valid | wb.alu_write;
        alu_cand_word  = alu_hold_valid ? alu_hold_word : wb.alu_word;
        alu_cand_d     = alu_hold_valid ? alu_hold_d    : alu_in_d;
        alu_cand_rd    = alu_hold_valid ? alu_hold_rd   : alu_in_rd;

        ptr_cand_valid = ptr_hold_valid | wb.ptr_write;
        ptr_cand_d     = ptr_hold_valid ? ptr_hold_d  : ptr_in_d;
        ptr_cand_rd    = ptr_hold_valid ? ptr_hold_rd : wb.ptr_Rd;

        win_valid = 1'b0;
        win_word  = 1'b0;
        win_d     = 6'd0;
        win_rd    = 16'd0;
        if (ld_ret) begin
            win_valid = 1'b1;
            win_d     = ld_dest_q;
            win_rd    = {8'h00, wb.mem_rdata};
        end else if (alu_cand_valid) begin
            win_valid = 1'b1;
            win_word  = alu_cand_word;
            win_d     = alu_cand_d;
            win_rd    = alu_cand_rd;
        end else if (ptr_cand_valid) begin
            win_valid = 1'b1;
            win_word  = 1'b1;
            win_d     = ptr_cand_d;
            win_rd    = ptr_cand_rd;
        end

        // Writes already on the output register are covered by the regfile
        // bypass, so only held entries and the pending load count here.
        hazard = (alu_hold_valid & reads_hit(wb.hz_a, wb.hz_b, alu_hold_d, alu_hold_word))
               | (ptr_hold_valid & reads_hit(wb.hz_a, wb.hz_b, ptr_hold_d, 1'b1))
               | (ld_pending_q   & reads_hit(wb.hz_a, wb.hz_b, ld_dest_q, 1'b0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_pending_q   <= 1'b0;
            ld_dest_q      <= 6'd0;
            alu_hold_valid <= 1'b0;
            alu_hold_word  <= 1'b0;
            alu_hold_d     <= 6'd0;
            alu_hold_rd    <= 16'd0;
            ptr_hold_valid <= 1'b0;
            ptr_hold_d     <= 6'd0;
            ptr_hold_rd    <= 16'd0;
            write_q        <= 1'b0;
            write_word_q   <= 1'b0;
            d_q            <= 6'd0;
            rd_q           <= 16'd0;
            err_q          <= 1'b0;
        end else begin
            write_q <= win_valid;
            if (win_valid) begin
                write_word_q <= win_word;
                d_q          <= win_d;
                rd_q         <= win_rd;
            end

            // Only one load can be outstanding. A second issue is a protocol
            // error, and a return with nothing pending is dropped.
            if (ld_pending_q) begin
                if (wb.mem_valid)
                    ld_pending_q <= 1'b0;
                if (wb.ld_issue)
                    err_q <= 1'b1;
            end else if (wb.ld_issue) begin
                ld_pending_q <= 1'b1;
                ld_dest_q    <= wb.ld_d;
            end

            // ALU hold: drains whenever no load return outranks it. A new
            // result arriving while it is occupied is lost (overrun).
            if (alu_hold_valid) begin
                if (!ld_ret)
                    alu_hold_valid <= 1'b0;
                if (wb.alu_write)
                    err_q <= 1'b1;
            end else if (wb.alu_write && ld_ret) begin
                alu_hold_valid <= 1'b1;
                alu_hold_word  <= wb.alu_word;
                alu_hold_d     <= alu_in_d;
                alu_hold_rd    <= alu_in_rd;
            end

            // Pointer hold: lowest priority, so it yields to both others.
            if (ptr_hold_valid) begin
                if (!ld_ret && !alu_cand_valid)
                    ptr_hold_valid <= 1'b0;
                if (wb.ptr_write)
                    err_q <= 1'b1;
            end else if (wb.ptr_write && (ld_ret || alu_cand_valid)) begin
                ptr_hold_valid <= 1'b1;
                ptr_hold_d     <= ptr_in_d;
                ptr_hold_rd    <= wb.ptr_Rd;
            end
        end
    end

    assign wb.stall      = alu_hold_valid | ptr_hold_valid | hazard;
    assign wb.write      = write_q;
    assign wb.write_word = write_word_q;
    assign wb.d          = d_q;
    assign wb.Rd         = rd_q;
    assign wb.ld_pending = ld_pending_q;
    assign wb.err        = err_q;

endmodule

// File: tb/tb_risc8_writeback.sv
// tb_risc8_writeback
// Bench for risc8_writeback. Expected register-file writes ({word, d, Rd})
// are queued with the cycle they are due. A negedge monitor pops each queued
// write and compares it against the DUT output. Scenario tasks drive inputs
// at the negedge and check stall, ld_pending, err and idle cycles inline.
module tb_risc8_writeback;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [22:0] exp_q[$];
    int          due_q[$];

    risc8_writeback_if wb();

    risc8_writeback dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [22:0] exp;
        int          due;
        if (wb.write === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got write d=%0d Rd=%h word=%0b at cycle %0d, required no write",
                         wb.d, wb.Rd, wb.write_word, cyc);
            end else begin
                exp = exp_q.pop_front();
                due = due_q.pop_front();
                if ({wb.write_word, wb.d, wb.Rd} !== exp || due != cyc) begin
                    n_fail++;
                    $display("FAIL wb_data: got word=%0b d=%0d Rd=%h at cycle %0d, required word=%0b d=%0d Rd=%h at cycle %0d",
                             wb.write_word, wb.d, wb.Rd, cyc, exp[22], exp[21:16], exp[15:0], due);
                end
            end
        end else if (exp_q.size() != 0 && due_q[0] <= cyc) begin
            n_cmp++;
            n_fail++;
            exp = exp_q.pop_front();
            due = due_q.pop_front();
            $display("FAIL wb_missing: got no write at cycle %0d, required d=%0d Rd=%h due at cycle %0d",
                     cyc, exp[21:16], exp[15:0], due);
        end
    end

    task automatic push_exp(input logic word, input logic [5:0] dd, input logic [15:0] rd, input int lat);
        exp_q.push_back({word, dd, rd});
        due_q.push_back(cyc + lat);
    endtask

    task automatic idle_inputs;
        wb.alu_write = 0; wb.alu_word = 0; wb.alu_d = 0; wb.alu_Rd = 0;
        wb.ptr_write = 0; wb.ptr_d = 0; wb.ptr_Rd = 0;
        wb.ld_issue = 0; wb.ld_d = 0; wb.mem_valid = 0; wb.mem_rdata = 0;
        wb.hz_a = 0; wb.hz_b = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({wb.write, wb.write_word, wb.d, wb.Rd} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got write=%0b word=%0b d=%0d Rd=%h, required all 0",
                     wb.write, wb.write_word, wb.d, wb.Rd);
        end
        n_cmp++;
        if ({wb.ld_pending, wb.err, wb.stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got ld_pending=%0b err=%0b stall=%0b, required 0 0 0",
                     wb.ld_pending, wb.err, wb.stall);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu_byte;
        @(negedge clk);
        wb.alu_write = 1; wb.alu_word = 0; wb.alu_d = 6'd5; wb.alu_Rd = 16'h12A7;
        push_exp(1'b0, 6'd5, 16'h00A7, 1);
        #1;
        n_cmp++;
        if (wb.stall !== 1'b0) begin
            n_fail++; $display("FAIL alu_byte_stall0: got %0b, required 0", wb.stall);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (wb.stall !== 1'b0) begin
            n_fail++; $display("FAIL alu_byte_stall1: got %0b, required 0", wb.stall);
        end
        @(negedge clk);
        n_cmp++;
        if (wb.write !== 1'b0) begin
            n_fail++; $display("FAIL alu_byte_idle: got write=%0b, required 0", wb.write);
        end
    endtask

    task automatic test_load_hazard;
        @(negedge clk);
        wb.ld_issue = 1; wb.ld_d = 6'd17;
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if (wb.ld_pending !== 1'b1) begin
            n_fail++; $display("FAIL ld_pending_set: got %0b, required 1", wb.ld_pending);
        end
        wb.hz_b = 6'd17; #1;
        n_cmp++;
        if (wb.stall !== 1'b1) begin
            n_fail++; $display("FAIL hazard_hz_b17: got stall=%0b, required 1", wb.stall);
        end
        wb.hz_b = 6'd0; wb.hz_a = 6'd16; #1;
        n_cmp++;
        if (wb.stall !== 1'b1) begin
            n_fail++; $display("FAIL hazard_hz_a16: got stall=%0b, required 1", wb.stall);
        end
        wb.hz_a = 6'd0; wb.hz_b = 6'd18; #1;
        n_cmp++;
        if (wb.stall !== 1'b0) begin
            n_fail++; $display("FAIL hazard_hz_b18: got stall=%0b, required 0", wb.stall);
        end
        repeat (2) @(negedge clk);
        idle_inputs();
        wb.mem_valid = 1; wb.mem_rdata = 8'h3C;
        push_exp(1'b0, 6'd17, 16'h003C, 1);
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if (wb.ld_pending !== 1'b0) begin
            n_fail++; $display("FAIL ld_pending_clear: got %0b, required 0", wb.ld_pending);
        end
        @(negedge clk);
    endtask

    task automatic test_triple_collision;
        @(negedge clk);
        wb.ld_issue = 1; wb.ld_d = 6'd2;
        @(negedge clk);
        idle_inputs();
        wb.mem_valid = 1; wb.mem_rdata = 8'h11;
        wb.alu_write = 1; wb.alu_word = 1; wb.alu_d = 6'd7; wb.alu_Rd = 16'hBEEF;
        wb.ptr_write = 1; wb.ptr_d = 6'd30; wb.ptr_Rd = 16'h0101;
        push_exp(1'b0, 6'd2, 16'h0011, 1);
        push_exp(1'b1, 6'd6, 16'hBEEF, 2);
        push_exp(1'b1, 6'd30, 16'h0101, 3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            n_cmp++;
            if (wb.stall !== 1'b1) begin
                n_fail++; $display("FAIL triple_drain_stall%0d: got %0b, required 1", i, wb.stall);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (wb.stall !== 1'b0 || wb.err !== 1'b0) begin
            n_fail++; $display("FAIL triple_after: got stall=%0b err=%0b, required 0 0", wb.stall, wb.err);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun;
        @(negedge clk);
        wb.ld_issue = 1; wb.ld_d = 6'd20;
        @(negedge clk);
        idle_inputs();
        wb.mem_valid = 1; wb.mem_rdata = 8'h55;
        wb.alu_write = 1; wb.alu_word = 0; wb.alu_d = 6'd9; wb.alu_Rd = 16'h1233;
        push_exp(1'b0, 6'd20, 16'h0055, 1);
        push_exp(1'b0, 6'd9, 16'h0033, 2);
        @(negedge clk);
        idle_inputs();
        wb.alu_write = 1; wb.alu_word = 0; wb.alu_d = 6'd10; wb.alu_Rd = 16'h0044;
        #1;
        n_cmp++;
        if (wb.stall !== 1'b1) begin
            n_fail++; $display("FAIL overrun_hold_stall: got %0b, required 1", wb.stall);
        end
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if (wb.err !== 1'b1) begin
            n_fail++; $display("FAIL overrun_err: got %0b, required 1", wb.err);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wb.err !== 1'b1) begin
            n_fail++; $display("FAIL overrun_err_sticky: got %0b, required 1", wb.err);
        end
    endtask

    task automatic test_load_protocol;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wb.ld_issue = 1; wb.ld_d = 6'd12;
        @(negedge clk);
        wb.ld_issue = 1; wb.ld_d = 6'd13;
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if (wb.err !== 1'b1 || wb.ld_pending !== 1'b1) begin
            n_fail++; $display("FAIL double_issue: got err=%0b ld_pending=%0b, required 1 1", wb.err, wb.ld_pending);
        end
        wb.mem_valid = 1; wb.mem_rdata = 8'h77;
        push_exp(1'b0, 6'd12, 16'h0077, 1);
        @(negedge clk);
        wb.mem_valid = 1; wb.mem_rdata = 8'h88;  // stray: nothing pending
        n_cmp++;
        if (wb.ld_pending !== 1'b0) begin
            n_fail++; $display("FAIL ld_return_clear: got %0b, required 0", wb.ld_pending);
        end
        @(negedge clk);
        wb.mem_valid = 1; wb.mem_rdata = 8'h99;  // same cycle as issue: ignored
        wb.ld_issue = 1; wb.ld_d = 6'd14;
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if (wb.ld_pending !== 1'b1) begin
            n_fail++; $display("FAIL issue_with_mem_valid: got ld_pending=%0b, required 1", wb.ld_pending);
        end
        wb.mem_valid = 1; wb.mem_rdata = 8'h5A;
        push_exp(1'b0, 6'd14, 16'h005A, 1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        wb.ld_issue = 1; wb.ld_d = 6'd21;
        @(negedge clk);
        idle_inputs();
        wb.alu_write = 1; wb.alu_word = 0; wb.alu_d = 6'd8; wb.alu_Rd = 16'h0066;
        wb.ptr_write = 1; wb.ptr_d = 6'd26; wb.ptr_Rd = 16'h1234;
        push_exp(1'b0, 6'd8, 16'h0066, 1);
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (wb.stall !== 1'b1 || wb.ld_pending !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_state: got stall=%0b ld_pending=%0b, required 1 1", wb.stall, wb.ld_pending);
        end
        reset = 1'b1;
        @(negedge clk);
        wb.hz_b = 6'd21;
        #1;
        n_cmp++;
        if ({wb.write, wb.write_word, wb.d, wb.Rd, wb.ld_pending, wb.err, wb.stall} !== 27'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got write=%0b word=%0b d=%0d Rd=%h ld_pending=%0b err=%0b stall=%0b, required all 0",
                     wb.write, wb.write_word, wb.d, wb.Rd, wb.ld_pending, wb.err, wb.stall);
        end
        reset = 1'b0;
        wb.hz_b = 6'd0;
        wb.mem_valid = 1; wb.mem_rdata = 8'h99;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (wb.write !== 1'b0 || wb.ld_pending !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_mem_valid: got write=%0b ld_pending=%0b, required 0 0", wb.write, wb.ld_pending);
        end
    endtask

    initial begin
        test_reset();
        test_alu_byte();
        test_load_hazard();
        test_triple_collision();
        test_overrun();
        test_load_protocol();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
